circularity_engine: RTL and testbench
=====================================

// Module: circularity_engine
// PURPOSE
//  Parametrised successor of the blob circularity calculator. Accepts tagged
//  (area, perimeter) pairs from the blob stats stage via valid/ready and
//  computes circularity = 4*PI_X100*area / perimeter^2 with an internal
//  radix-2 restoring divider. Result is clamped to SAT_MAX, and a zero
//  perimeter is flagged as an error. Output is held until the downstream
//  classifier accepts it.
// PARAMETERS
//  WIDTH     180                  frame width in pixels
//  HEIGHT    320                  frame height in pixels
//  AP_W      $clog2(WIDTH*HEIGHT)+1  area/perimeter width (17 at default)
//  PI_X100   314                  pi*100 scale constant
//  OUT_W     8                    circularity result width
//  SAT_MAX   100                  clamp ceiling; must be < 2**OUT_W
//  TAG_W     2                    blob/channel tag width
//  DVD_W     AP_W+$clog2(4*PI_X100)+1  dividend width; also the divide iteration count
// PORTS
//  clk_in           in   1        single system clock
//  rst_n_in         in   1        reset: asynchronous, active-low
//  area_in          in   AP_W     blob pixel count
//  perimeter_in     in   AP_W     blob edge pixel count
//  tag_in           in   TAG_W    blob/channel id carried to the output
//  valid_in         in   1        input pair valid
//  ready_out        out  1        engine can accept (high only in IDLE)
//  circularity_out  out  OUT_W    clamped quotient (0..SAT_MAX)
//  tag_out          out  TAG_W    tag of the current result
//  sat_out          out  1        raw quotient exceeded SAT_MAX
//  error_out        out  1        perimeter was 0
//  valid_out        out  1        result valid; held until ready_in is high
//  ready_in         in   1        downstream accepts the result
//  busy_out         out  1        state != IDLE
// BEHAVIOUR
//  Reset (async assert on rst_n_in low, sync deassert handled upstream):
//   state=IDLE. ready_out=1 after reset. All other outputs are 0.
//   Any in-flight job is discarded and no output is produced for it.
//  FSM: IDLE -> PREP -> DIV -> SAT -> HOLD -> IDLE.
//   IDLE: when valid_in & ready_out, latch area, perimeter and tag; go to PREP.
//   PREP: dividend = 4*PI_X100*area (DVD_W bits, no overflow at max area).
//         divisor = perimeter^2 (2*AP_W bits). Clear the remainder, load the
//         bit counter with DVD_W-1.
//         If perimeter==0: set err and go to SAT directly (no DIV state).
//   DIV: one quotient bit per cycle, MSB first, for DVD_W cycles. Per cycle:
//         rem = {rem, next dividend bit}; if rem >= divisor, then rem -= divisor
//         and q bit = 1. The remainder register is 2*AP_W+1 bits.
//   SAT: if err, circ=0. Else if q > SAT_MAX, circ=SAT_MAX and sat=1.
//         Else circ=q[OUT_W-1:0]. Go to HOLD.
//   HOLD: valid_out=1. circularity_out, tag_out, sat_out and error_out stay
//         stable. When ready_in=1, the handshake completes that cycle and the
//         next state is IDLE.
//  Latency, accept edge to valid_out rising: DVD_W+2 cycles (error path: 2).
//  Throughput: one job per DVD_W+4 cycles with ready_in tied high.
//  ready_out = (state==IDLE). valid_in is ignored in all other states.
//  Back-to-back: a new job can be accepted on the first IDLE cycle after the
//   HOLD handshake. There is no skid buffer.
//  ready_in high before valid_out has no effect. valid_out never drops
//   without a handshake (except on reset).
//  area=0 with perimeter!=0 gives circ=0, sat=0, err=0.
//  The quotient is truncated, not rounded.
// TESTING
//  1 area=100, perimeter=40, tag=1 -> after DVD_W+2 cycles: circ=78, tag_out=1,
//    sat=0, err=0.
//  2 area=314, perimeter=63 -> circ=99 (394384/3969 truncated).
//  3 area=100, perimeter=20 -> raw 314 -> circ=100, sat_out=1.
//  4 perimeter=0, area=50 -> valid_out 2 cycles after accept, circ=0,
//    error_out=1.
//  5 ready_in low for 5 cycles in HOLD -> outputs stable, ready_out=0,
//    a second valid_in is not accepted; then ready_in=1 -> IDLE, second job
//    accepted next cycle.
//  6 rst_n_in low mid-DIV -> outputs go to 0 immediately, no valid_out for
//    the aborted job; a fresh job after release completes with the correct
//    result.

Source files
------------

// File: rtl/circularity_engine.sv
// Circularity engine: 4*PI_X100*area / perimeter^2 via a radix-2 restoring divider,
// clamped to SAT_MAX, zero perimeter flagged as error, result held until accepted.
module circularity_engine #(
    parameter int WIDTH   = 180,
    parameter int HEIGHT  = 320,
    parameter int AP_W    = $clog2(WIDTH*HEIGHT)+1,
    parameter int PI_X100 = 314,
    parameter int OUT_W   = 8,
    parameter int SAT_MAX = 100,
    parameter int TAG_W   = 2,
    parameter int DVD_W   = AP_W+$clog2(4*PI_X100)+1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [AP_W-1:0]   area_in,
    input  logic [AP_W-1:0]   perimeter_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [OUT_W-1:0]  circularity_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              sat_out,
    output logic              error_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              busy_out
);
    localparam int CNT_W = $clog2(DVD_W);
    localparam int DVS_W = 2*AP_W;
    localparam int REM_W = 2*AP_W+1;
    localparam logic [DVD_W-1:0] K_SCALE = DVD_W'(4*PI_X100);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_SAT, S_HOLD} state_t;

    state_t             r_state, w_next;
    logic [AP_W-1:0]    r_area, r_per;
    logic [TAG_W-1:0]   r_tag;
    logic [DVD_W-1:0]   r_dvd, r_q;
    logic [DVS_W-1:0]   r_dvs;
    logic [REM_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [OUT_W-1:0]   r_circ;
    logic [TAG_W-1:0]   r_tag_o;
    logic               r_sat_o, r_err_o;

    logic [DVD_W-1:0]   w_dvd;
    logic [DVS_W-1:0]   w_dvs;
    logic [REM_W-1:0]   w_rem_shift, w_rem_sub;
    logic               w_ge;

    assign w_dvd = K_SCALE * {{(DVD_W-AP_W){1'b0}}, r_area};
    assign w_dvs = {{AP_W{1'b0}}, r_per} * {{AP_W{1'b0}}, r_per};

    // The bit shifted out of r_rem is folded into the compare so the 36-bit
    // partial remainder is handled exactly without widening the register.
    assign w_rem_shift = {r_rem[REM_W-2:0], r_dvd[DVD_W-1]};
    assign w_ge        = r_rem[REM_W-1] || (w_rem_shift >= {1'b0, r_dvs});
    assign w_rem_sub   = w_rem_shift - {1'b0, r_dvs};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (valid_in)          w_next = S_PREP;
            S_PREP: w_next = (r_per == '0) ? S_SAT : S_DIV;
            S_DIV:  if (r_cnt == '0)       w_next = S_SAT;
            S_SAT:  w_next = S_HOLD;
            S_HOLD: if (ready_in)          w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out = (r_state == S_IDLE);
        busy_out  = (r_state != S_IDLE);
        valid_out = (r_state == S_HOLD);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_area  <= '0;
            r_per   <= '0;
            r_tag   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_circ  <= '0;
            r_tag_o <= '0;
            r_sat_o <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (valid_in) begin
                    r_area <= area_in;
                    r_per  <= perimeter_in;
                    r_tag  <= tag_in;
                end
                S_PREP: begin
                    r_dvd <= w_dvd;
                    r_dvs <= w_dvs;
                    r_rem <= '0;
                    r_q   <= '0;
                    r_cnt <= CNT_W'(DVD_W-1);
                    r_err <= (r_per == '0);
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_rem_sub : w_rem_shift;
                    r_q   <= {r_q[DVD_W-2:0], w_ge};
                    r_dvd <= {r_dvd[DVD_W-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                end
                S_SAT: begin
                    r_tag_o <= r_tag;
                    r_err_o <= r_err;
                    if (r_err) begin
                        r_circ  <= '0;
                        r_sat_o <= 1'b0;
                    end else if (r_q > DVD_W'(SAT_MAX)) begin
                        r_circ  <= OUT_W'(SAT_MAX);
                        r_sat_o <= 1'b1;
                    end else begin
                        r_circ  <= r_q[OUT_W-1:0];
                        r_sat_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign circularity_out = r_circ;
    assign tag_out         = r_tag_o;
    assign sat_out         = r_sat_o;
    assign error_out       = r_err_o;
endmodule

// File: tb/tb_circularity_engine.sv
// Directed self-checking bench for circularity_engine at default parameters
// (AP_W=17, DVD_W=29, so result latency is 31 cycles, error path 2).
module tb_circularity_engine;
    localparam int AP_W  = 17;
    localparam int TAG_W = 2;
    localparam int OUT_W = 8;
    localparam int DVD_W = 29;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [AP_W-1:0]   area_in;
    logic [AP_W-1:0]   perimeter_in;
    logic [TAG_W-1:0]  tag_in;
    logic              valid_in;
    logic              ready_out;
    logic [OUT_W-1:0]  circularity_out;
    logic [TAG_W-1:0]  tag_out;
    logic              sat_out;
    logic              error_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy_out;

    int errors = 0;
    int checks = 0;

    circularity_engine dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .area_in(area_in), .perimeter_in(perimeter_in), .tag_in(tag_in),
        .valid_in(valid_in), .ready_out(ready_out),
        .circularity_out(circularity_out), .tag_out(tag_out),
        .sat_out(sat_out), .error_out(error_out), .valid_out(valid_out),
        .ready_in(ready_in), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid_out !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (valid_out !== 1'b1) lat = -1;
    endtask

    task automatic send(input logic [AP_W-1:0] a, input logic [AP_W-1:0] p,
                        input logic [TAG_W-1:0] t, output int lat);
        area_in = a; perimeter_in = p; tag_in = t; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        wait_valid(lat);
    endtask

    task automatic handshake();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        area_in = '0; perimeter_in = '0; tag_in = '0;
        tick(); tick();
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
        checks++; if ({circularity_out, tag_out, sat_out, error_out} !== '0) begin
            errors++; $display("FAIL reset_outs circ=%0d tag=%0d sat=%b err=%b exp all 0",
                               circularity_out, tag_out, sat_out, error_out); end
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        send(17'd100, 17'd40, 2'd1, lat);
        checks++; if (lat !== DVD_W+2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, DVD_W+2); end
        checks++; if (circularity_out !== 8'd78) begin errors++; $display("FAIL basic_circ got=%0d exp=78", circularity_out); end
        checks++; if (tag_out !== 2'd1) begin errors++; $display("FAIL basic_tag got=%0d exp=1", tag_out); end
        checks++; if ({sat_out, error_out} !== 2'b00) begin errors++; $display("FAIL basic_flags got=%b exp=00", {sat_out, error_out}); end
        handshake();
        checks++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL basic_release valid=%b ready=%b exp 0/1", valid_out, ready_out); end

        send(17'd314, 17'd63, 2'd2, lat);
        checks++; if (circularity_out !== 8'd99) begin errors++; $display("FAIL trunc_circ got=%0d exp=99", circularity_out); end
        checks++; if (tag_out !== 2'd2) begin errors++; $display("FAIL trunc_tag got=%0d exp=2", tag_out); end
        handshake();
    endtask

    task automatic test_saturation();
        int lat;
        send(17'd100, 17'd20, 2'd3, lat);
        checks++; if (circularity_out !== 8'd100) begin errors++; $display("FAIL sat_circ got=%0d exp=100", circularity_out); end
        checks++; if ({sat_out, error_out} !== 2'b10) begin errors++; $display("FAIL sat_flags got=%b exp=10", {sat_out, error_out}); end
        handshake();
        send(17'h1FFFF, 17'd1, 2'd0, lat);
        checks++; if (circularity_out !== 8'd100 || sat_out !== 1'b1) begin
            errors++; $display("FAIL maxarea_sat circ=%0d sat=%b exp 100/1", circularity_out, sat_out); end
        handshake();
        send(17'd0, 17'd5, 2'd1, lat);
        checks++; if ({circularity_out, sat_out, error_out} !== 10'd0) begin
            errors++; $display("FAIL zero_area circ=%0d sat=%b err=%b exp 0/0/0", circularity_out, sat_out, error_out); end
        handshake();
    endtask

    task automatic test_error();
        int lat;
        send(17'd50, 17'd0, 2'd2, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL err_latency got=%0d exp=2", lat); end
        checks++; if ({circularity_out, sat_out, error_out} !== 10'b1) begin
            errors++; $display("FAIL err_outs circ=%0d sat=%b err=%b exp 0/0/1", circularity_out, sat_out, error_out); end
        checks++; if (tag_out !== 2'd2) begin errors++; $display("FAIL err_tag got=%0d exp=2", tag_out); end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        send(17'd100, 17'd40, 2'd0, lat);
        area_in = 17'd314; perimeter_in = 17'd63; tag_in = 2'd2; valid_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid_out !== 1'b1 || ready_out !== 1'b0 || circularity_out !== 8'd78 || tag_out !== 2'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        checks++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            errors++; $display("FAIL b2b_idle ready=%b valid=%b exp 1/0", ready_out, valid_out); end
        tick();
        valid_in = 1'b0;
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", busy_out); end
        wait_valid(lat);
        checks++; if (lat !== DVD_W+2) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, DVD_W+2); end
        checks++; if (circularity_out !== 8'd99 || tag_out !== 2'd2) begin
            errors++; $display("FAIL b2b_result circ=%0d tag=%0d exp 99/2", circularity_out, tag_out); end
        handshake();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        area_in = 17'd100; perimeter_in = 17'd20; tag_in = 2'd3; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy_out); end
        rst_n_in = 1'b0;
        #1;
        checks++; if (valid_out !== 1'b0 || busy_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL abort_ctrl valid=%b busy=%b ready=%b exp 0/0/1", valid_out, busy_out, ready_out); end
        checks++; if ({circularity_out, tag_out, sat_out, error_out} !== '0) begin
            errors++; $display("FAIL abort_outs circ=%0d tag=%0d exp 0/0", circularity_out, tag_out); end
        tick();
        rst_n_in = 1'b1;
        seen = 0;
        for (int i = 0; i < DVD_W+8; i++) begin
            tick();
            if (valid_out !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid cycles=%0d exp=0", seen); end
        send(17'd314, 17'd63, 2'd1, lat);
        checks++; if (lat !== DVD_W+2 || circularity_out !== 8'd99 || tag_out !== 2'd1) begin
            errors++; $display("FAIL post_reset lat=%0d circ=%0d tag=%0d exp %0d/99/1", lat, circularity_out, tag_out, DVD_W+2); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
